// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the snake-game VGA block: snake cell codes, default
// 640x480@60 timing, default 12-bit palette, the S1 pipeline flag bundle and
// the per-channel colour halving used by the pause (dim) screen.
// ---------------------------------------------------------------------------
package vga_pkg;

    // Cell codes returned by the game logic for the queried cell.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_HEAD  = 2'b01;
    localparam logic [1:0] CELL_BODY  = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    // Default 640x480 timing (pixels / lines).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Raster counter width; covers totals up to 4095.
    localparam int CNT_W = 12;

    // Widest colour the halving helper handles.
    localparam int MAX_COLOR_W = 36;

    // Default palette for a 12-bit (4:4:4) colour bus.
    localparam logic [11:0] DEF_COL_HEAD  = 12'h0F0;
    localparam logic [11:0] DEF_COL_BODY  = 12'h0A0;
    localparam logic [11:0] DEF_COL_WALL  = 12'h888;
    localparam logic [11:0] DEF_COL_APPLE = 12'hF00;
    localparam logic [11:0] DEF_COL_BG    = 12'h000;

    // Raster decode carried from S1 to S2 alongside x_pos/y_pos.
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic first;
    } s1_flags_t;

    // Shift every ch_w-bit channel right by one: each result bit takes the
    // next-higher input bit, except a channel MSB which becomes 0.
    function automatic logic [MAX_COLOR_W-1:0] halve_channels(
        input logic [MAX_COLOR_W-1:0] color,
        input int                     ch_w
    );
        logic [MAX_COLOR_W-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_COLOR_W - 1; i++) begin
            result[i] = (((i + 1) % ch_w) == 0) ? 1'b0 : color[i + 1];
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Pixel clock-enable and raster counters with visible/sync decode.
//   clk, rst      : system clock, synchronous active-high reset
//   pix_en        : one clk in every CLK_DIV (always 1 when CLK_DIV == 1)
//   h_cnt, v_cnt  : raster position, advance on pix_en only
//   vis, hs, vs   : decoded from the current counters (sync active-high here)
//   first         : counters sit at pixel (0,0)
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             vis,
    output logic             hs,
    output logic             vs,
    output logic             first
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [DIV_W-1:0] div;

    // With CLK_DIV == 1 div is stuck at 0 == DIV_LAST, so pix_en is constant 1.
    assign pix_en = (div == DIV_LAST);

    // NOTE: registered state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= pix_en ? '0 : div + DIV_W'(1);
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign first = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_grid_display.sv
// ---------------------------------------------------------------------------
// vga_grid_display
// VGA output for the snake game: timing generator plus a two-stage grid
// renderer. S1 registers the queried cell and raster flags; S2 samples the
// game's cell code and registers colour, syncs, de and frame_start, so all
// outputs trail the counters by exactly two pixel periods.
//   clk, rst     : system clock, synchronous active-high reset
//   snake        : cell code at (x_pos, y_pos) from the game logic
//   apple_x/y    : apple cell; VGA_reward overrides its colour when non-zero
//   dim          : halve every colour channel (pause screen)
//   x_pos, y_pos : queried cell (also updated during blanking)
//   hsync, vsync : syncs, level HS_POL / VS_POL when active
//   de           : colour_out is a visible pixel
//   frame_start  : one-clk pulse as pixel (0,0) appears on the outputs
//   color_out    : pixel colour, 0 in blanking
// ---------------------------------------------------------------------------
module vga_grid_display
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = 4,
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CELL_LOG2 = 4,
    // Three equal channels, at most MAX_COLOR_W bits.
    parameter int   COLOR_W   = 12,
    parameter logic [COLOR_W-1:0] COL_HEAD  = COLOR_W'(DEF_COL_HEAD),
    parameter logic [COLOR_W-1:0] COL_BODY  = COLOR_W'(DEF_COL_BODY),
    parameter logic [COLOR_W-1:0] COL_WALL  = COLOR_W'(DEF_COL_WALL),
    parameter logic [COLOR_W-1:0] COL_APPLE = COLOR_W'(DEF_COL_APPLE),
    parameter logic [COLOR_W-1:0] COL_BG    = COLOR_W'(DEF_COL_BG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         snake,
    input  logic [5:0]         apple_x,
    input  logic [4:0]         apple_y,
    input  logic [COLOR_W-1:0] VGA_reward,
    input  logic               dim,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic [COLOR_W-1:0] color_out
);

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             vis;
    logic             hs;
    logic             vs;
    logic             first;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .pix_en(pix_en),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .vis   (vis),
        .hs    (hs),
        .vs    (vs),
        .first (first)
    );

    // S1: present the cell query to the game logic and carry the raster flags.
    s1_flags_t s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_pos <= '0;
            y_pos <= '0;
            s1    <= '0;
        end else if (pix_en) begin
            x_pos <= 10'(h_cnt >> CELL_LOG2);
            y_pos <= 10'(v_cnt >> CELL_LOG2);
            s1    <= '{vis: vis, hs: hs, vs: vs, first: first};
        end
    end

    // Colour mux; snake has had a full pixel period to settle since S1.
    logic               apple_hit;
    logic [COLOR_W-1:0] pixel_color;
    logic [COLOR_W-1:0] dim_color;

    assign apple_hit = (x_pos == {4'b0000, apple_x}) && (y_pos == {5'b00000, apple_y});

    // NOTE: pixel_color gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pixel_color = COL_BG;
        if (!s1.vis)                 pixel_color = '0;
        else if (snake == CELL_HEAD) pixel_color = COL_HEAD;
        else if (snake == CELL_BODY) pixel_color = COL_BODY;
        else if (snake == CELL_WALL) pixel_color = COL_WALL;
        else if (apple_hit)          pixel_color = (VGA_reward != '0) ? VGA_reward : COL_APPLE;
    end

    assign dim_color = COLOR_W'(halve_channels(MAX_COLOR_W'(pixel_color), COLOR_W / 3));

    // S2: register everything that leaves the block on the same pix_en edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_out   <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            // Updated every clk so the pulse lasts one clk, not one pixel.
            frame_start <= pix_en & s1.first;
            if (pix_en) begin
                color_out <= dim ? dim_color : pixel_color;
                de        <= s1.vis;
                hsync     <= s1.hs ? HS_POL : ~HS_POL;
                vsync     <= s1.vs ? VS_POL : ~VS_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_grid_display.sv
// ---------------------------------------------------------------------------
// tb_vga_grid_display
// Three instances share clk/rst:
//   dut_a : CLK_DIV=4, compact 32x24 raster (40x28 total), 4x4-pixel cells
//   dut_b : CLK_DIV=1, same raster, active-high syncs
//   dut_c : all defaults (640x480, CLK_DIV=4)
// k counts clk edges since reset release. Pixel p (row-major over the full
// raster) reaches the outputs at edge (p+2)*CLK_DIV; all expectations derive
// from k and the geometry below.
// ---------------------------------------------------------------------------
module tb_vga_grid_display;

    localparam int A_D = 4;
    localparam int HA  = 32;
    localparam int VA  = 24;
    localparam int HT  = 40;
    localparam int VT  = 28;
    localparam int FR  = HT * VT;
    localparam int C_HT = 800;
    localparam int C_FR = 800 * 525;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // ---------------- dut_a ----------------
    logic [1:0]  snake_a;
    logic [5:0]  apple_x_a = 6'd63;
    logic [4:0]  apple_y_a = 5'd31;
    logic [11:0] reward_a  = 12'h000;
    logic        dim_a     = 1'b0;
    logic [9:0]  x_pos_a, y_pos_a;
    logic        hsync_a, vsync_a, de_a, frame_start_a;
    logic [11:0] color_out_a;

    // Game-logic stand-in for dut_a.
    logic       head_on = 1'b0, body_on = 1'b0, wall_all = 1'b0;
    logic [9:0] head_cx = 10'd3, head_cy = 10'd2, body_cx = 10'd5, body_cy = 10'd5;

    assign snake_a = (head_on && x_pos_a == head_cx && y_pos_a == head_cy) ? 2'b01 :
                     (body_on && x_pos_a == body_cx && y_pos_a == body_cy) ? 2'b10 :
                     wall_all ? 2'b11 : 2'b00;

    vga_grid_display #(
        .CLK_DIV(A_D), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1), .CELL_LOG2(2)
    ) dut_a (
        .clk(clk), .rst(rst), .snake(snake_a), .apple_x(apple_x_a), .apple_y(apple_y_a),
        .VGA_reward(reward_a), .dim(dim_a), .x_pos(x_pos_a), .y_pos(y_pos_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(frame_start_a),
        .color_out(color_out_a)
    );

    // ---------------- dut_b ----------------
    logic [1:0]  snake_b;
    logic [9:0]  x_pos_b, y_pos_b;
    logic        hsync_b, vsync_b, de_b, frame_start_b;
    logic [11:0] color_out_b;

    assign snake_b = (x_pos_b == 10'd1) ? 2'b11 : 2'b00;

    vga_grid_display #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1), .CELL_LOG2(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .snake(snake_b), .apple_x(6'd63), .apple_y(5'd31),
        .VGA_reward(12'h000), .dim(1'b0), .x_pos(x_pos_b), .y_pos(y_pos_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(frame_start_b),
        .color_out(color_out_b)
    );

    // ---------------- dut_c ----------------
    logic [9:0]  x_pos_c, y_pos_c;
    logic        hsync_c, vsync_c, de_c, frame_start_c;
    logic [11:0] color_out_c;

    vga_grid_display dut_c (
        .clk(clk), .rst(rst), .snake(2'b00), .apple_x(6'd0), .apple_y(5'd0),
        .VGA_reward(12'h000), .dim(1'b0), .x_pos(x_pos_c), .y_pos(y_pos_c),
        .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .frame_start(frame_start_c),
        .color_out(color_out_c)
    );

    // Expected dut_a colour for raster pixel (h, v) under the current scenario.
    function automatic logic [11:0] model_a(input int h, input int v);
        int cx, cy;
        logic [11:0] c;
        if (h >= HA || v >= VA) return 12'h000;
        cx = h / 4;
        cy = v / 4;
        if (head_on && cx == int'(head_cx) && cy == int'(head_cy))      c = 12'h0F0;
        else if (body_on && cx == int'(body_cx) && cy == int'(body_cy)) c = 12'h0A0;
        else if (wall_all)                                              c = 12'h888;
        else if (cx == int'(apple_x_a) && cy == int'(apple_y_a))        c = (reward_a != 12'h000) ? reward_a : 12'hF00;
        else                                                            c = 12'h000;
        if (dim_a) c = {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
        return c;
    endfunction

    // Scan one full dut_a frame, one comparison per pixel.
    task automatic run_frame_a(input string tag);
        int guard, h, v;
        logic [11:0] ec;
        logic ede, ehs, evs;
        guard = 0;
        while (!(k >= 2 * A_D && ((k - 2 * A_D) % (A_D * FR)) == 0) && guard < 2 * A_D * FR) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2 * A_D * FR) begin
            checks++; errors++;
            $display("FAIL %s align: no frame boundary within %0d clk", tag, guard);
            return;
        end
        for (int p = 0; p < FR; p++) begin
            if (p > 0) repeat (A_D) @(negedge clk);
            h   = p % HT;
            v   = p / HT;
            ec  = model_a(h, v);
            ede = (h < HA) && (v < VA);
            ehs = !(h >= 34 && h < 38);
            evs = !(v >= 25 && v < 27);
            checks++;
            if ({color_out_a, de_a, hsync_a, vsync_a, frame_start_a} !== {ec, ede, ehs, evs, p == 0}) begin
                errors++;
                $display("FAIL %s pixel h=%0d v=%0d: got color=%h de=%b hs=%b vs=%b fs=%b, want color=%h de=%b hs=%b vs=%b fs=%b",
                         tag, h, v, color_out_a, de_a, hsync_a, vsync_a, frame_start_a, ec, ede, ehs, evs, p == 0);
            end
        end
    endtask

    // Three clk of reset, then release and follow the first pixels out.
    task automatic reset_and_release(input string tag);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({color_out_a, de_a, frame_start_a, hsync_a, vsync_a, x_pos_a, y_pos_a} !==
                {12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0}) begin
                errors++;
                $display("FAIL %s a_reset_values: got color=%h de=%b fs=%b hs=%b vs=%b x=%0d y=%0d, want 000 0 0 1 1 0 0",
                         tag, color_out_a, de_a, frame_start_a, hsync_a, vsync_a, x_pos_a, y_pos_a);
            end
            checks++;
            if ({color_out_b, de_b, frame_start_b, hsync_b, vsync_b, hsync_c, vsync_c} !==
                {12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL %s bc_reset_values: got b color=%h de=%b fs=%b hs=%b vs=%b c hs=%b vs=%b, want 000 0 0 0 0 1 1",
                         tag, color_out_b, de_b, frame_start_b, hsync_b, vsync_b, hsync_c, vsync_c);
            end
        end
        rst = 1'b0;
        // Edges 1..7: dut_a still shows reset-like outputs; dut_b frame_start at edge 2.
        for (int i = 0; i < 2 * A_D - 1; i++) begin
            @(negedge clk);
            checks++;
            if ({frame_start_a, de_a, hsync_a, frame_start_b} !== {1'b0, 1'b0, 1'b1, k == 2}) begin
                errors++;
                $display("FAIL %s startup k=%0d: got a_fs=%b a_de=%b a_hs=%b b_fs=%b, want 0 0 1 %b",
                         tag, k, frame_start_a, de_a, hsync_a, frame_start_b, k == 2);
            end
        end
    endtask

    task automatic test_reset();
        reset_and_release("reset");
    endtask

    task automatic test_frames_and_head();
        run_frame_a("frame1_bg");
        head_on = 1'b1;
        run_frame_a("frame2_head");
        head_on = 1'b0;
    endtask

    task automatic test_apple();
        apple_x_a = 6'd5;
        apple_y_a = 5'd5;
        reward_a  = 12'h000;
        run_frame_a("apple_default");
        reward_a = 12'h0FF;
        run_frame_a("apple_reward");
        body_on = 1'b1;
        run_frame_a("body_over_apple");
        body_on = 1'b0;
    endtask

    task automatic test_dim();
        wall_all = 1'b1;
        dim_a    = 1'b1;
        run_frame_a("dim_wall");
        wall_all = 1'b0;
        dim_a    = 1'b0;
    endtask

    // dut_b: per-clk pixel checks over a whole frame and the frame_start period.
    task automatic test_sweep_b();
        int guard, cnt, p, h, v;
        logic found;
        logic [11:0] ec;
        logic ede, ehs, evs;
        guard = 0;
        while (!(k >= 2 && ((k - 2) % FR) == 0) && guard < 2 * FR) begin
            @(negedge clk);
            guard++;
        end
        cnt   = 0;
        found = 1'b0;
        while (cnt <= 2 * FR) begin
            p   = (k - 2) % FR;
            h   = p % HT;
            v   = p / HT;
            ede = (h < HA) && (v < VA);
            ec  = (ede && h / 4 == 1) ? 12'h888 : 12'h000;
            ehs = (h >= 34 && h < 38);
            evs = (v >= 25 && v < 27);
            checks++;
            if ({color_out_b, de_b, hsync_b, vsync_b, frame_start_b} !== {ec, ede, ehs, evs, p == 0}) begin
                errors++;
                $display("FAIL sweep_b pixel h=%0d v=%0d: got color=%h de=%b hs=%b vs=%b fs=%b, want color=%h de=%b hs=%b vs=%b fs=%b",
                         h, v, color_out_b, de_b, hsync_b, vsync_b, frame_start_b, ec, ede, ehs, evs, p == 0);
            end
            if (cnt > 0 && frame_start_b === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (!found || cnt != FR) begin
            errors++;
            $display("FAIL sweep_b frame_period: got %0d clk (found=%b), want %0d", cnt, found, FR);
        end
    endtask

    // dut_c (defaults): two full lines of syncs, de, colour and the cell query.
    task automatic test_default_c();
        int guard, p, q, h, v;
        logic [11:0] ec;
        logic [9:0]  ex, ey;
        logic ede, ehs, evs;
        guard = 0;
        while (!(k >= 8 && (k % 4) == 0) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 2 * C_HT; i++) begin
            if (i > 0) repeat (4) @(negedge clk);
            p   = (k / 4 - 2) % C_FR;
            h   = p % C_HT;
            v   = p / C_HT;
            q   = (p + 1) % C_FR;
            ex  = 10'((q % C_HT) / 16);
            ey  = 10'((q / C_HT) / 16);
            ede = (h < 640) && (v < 480);
            ec  = (ede && h < 16 && v < 16) ? 12'hF00 : 12'h000;
            ehs = !(h >= 656 && h < 752);
            evs = !(v >= 490 && v < 492);
            checks++;
            if ({color_out_c, de_c, hsync_c, vsync_c, frame_start_c, x_pos_c, y_pos_c} !==
                {ec, ede, ehs, evs, p == 0, ex, ey}) begin
                errors++;
                $display("FAIL default_c pixel h=%0d v=%0d: got color=%h de=%b hs=%b vs=%b fs=%b x=%0d y=%0d, want color=%h de=%b hs=%b vs=%b fs=%b x=%0d y=%0d",
                         h, v, color_out_c, de_c, hsync_c, vsync_c, frame_start_c, x_pos_c, y_pos_c,
                         ec, ede, ehs, evs, p == 0, ex, ey);
            end
        end
    endtask

    // Reset mid-line on dut_a (output pixel h=20), then a clean frame.
    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!(k >= 8 && (k % 4) == 0 && (((k / 4 - 2) % FR) % HT) == 20) && guard < 2 * A_D * FR) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2 * A_D * FR) begin
            checks++; errors++;
            $display("FAIL reset_mid align: no h=20 within %0d clk", guard);
            return;
        end
        head_on = 1'b1;
        reset_and_release("reset_mid");
        run_frame_a("after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_frames_and_head();
        test_apple();
        test_dim();
        test_sweep_b();
        test_default_c();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
